// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: opcodes, operation codes,
// FSM state encoding, control levels and small decode helpers.
package mem_stage_pkg;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  localparam logic [5:0] OptNOP = 6'd0;
  localparam logic [5:0] OptLB  = 6'd1;
  localparam logic [5:0] OptLH  = 6'd2;
  localparam logic [5:0] OptLW  = 6'd3;
  localparam logic [5:0] OptLBU = 6'd4;
  localparam logic [5:0] OptLHU = 6'd5;
  localparam logic [5:0] OptSB  = 6'd6;
  localparam logic [5:0] OptSH  = 6'd7;
  localparam logic [5:0] OptSW  = 6'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic Stop    = 1'b1;
  localparam logic NoStop  = 1'b0;
  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  // Index of the final byte of an access (N-1); unknown codes act as words.
  function automatic logic [1:0] last_idx(input logic [5:0] opt);
    case (opt)
      OptLB, OptLBU, OptSB: last_idx = 2'd0;
      OptLH, OptLHU, OptSH: last_idx = 2'd1;
      default:              last_idx = 2'd3;
    endcase
  endfunction

  // Halfwords need bit 0 clear, words need bits 1:0 clear.
  function automatic logic is_misaligned(input logic [5:0] opt, input logic [1:0] lo);
    case (opt)
      OptLH, OptLHU, OptSH: is_misaligned = lo[0];
      OptLW, OptSW:         is_misaligned = |lo;
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load result extension: picks the low byte/halfword/word of the assembled
// buffer and sign- or zero-extends it according to the load operation.
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_buf,
  input  logic [5:0]        i_opt,
  output logic [DATA_W-1:0] o_data
);

  logic signed [7:0]  w_byte_s;
  logic signed [15:0] w_half_s;

  assign w_byte_s = i_buf[7:0];
  assign w_half_s = i_buf[15:0];

  // Select width and extension mode from the operation code.
  always_comb begin
    o_data = i_buf;
    case (i_opt)
      OptLB:   o_data = DATA_W'(w_byte_s);
      OptLH:   o_data = DATA_W'(w_half_s);
      OptLBU:  o_data = {{(DATA_W-8){1'b0}}, i_buf[7:0]};
      OptLHU:  o_data = {{(DATA_W-16){1'b0}}, i_buf[15:0]};
      default: o_data = i_buf;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: loads/stores run as byte-serial transactions on an
// 8-bit memory port while the pipeline is stalled; everything else passes
// straight through. Optional alignment trap enabled by MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        mem_opcode,
  input  logic [5:0]        mem_opt,
  input  logic              mem_we,
  input  logic [4:0]        mem_waddr,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic              mem_cond,
  input  logic [DATA_W-1:0] mem_rdata2,
  input  logic              mem_flag,
  output logic              ram_req,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_ready,
  output logic              stallreq_mem,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [DATA_W-1:0] wb_wdata
`ifdef MEM_ALIGN_CHECK_EN
  ,output logic             misalign_err
`endif
);

  state_e            r_state;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_buf;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_misalign;
  logic              w_start;
  logic [1:0]        w_last;
  logic [DATA_W-1:0] w_ext;
  logic              w_unused;

  // The branch condition only travels through this stage.
  assign w_unused   = mem_cond;

  assign w_is_load  = (mem_opcode == LOAD);
  assign w_is_store = (mem_opcode == STORE);
  assign w_is_mem   = mem_flag & (w_is_load | w_is_store);
  assign w_last     = last_idx(mem_opt);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_is_mem & is_misaligned(mem_opt, mem_alu[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start = w_is_mem & ~w_misalign;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .i_buf  (r_buf),
    .i_opt  (mem_opt),
    .o_data (w_ext)
  );

  // FSM, byte counter and load assembly buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= 2'd0;
          if (w_start) begin
            r_state <= BUSY;
            r_buf   <= '0;
          end
        end
        BUSY: begin
          if (ram_ready) begin
            if (w_is_load) r_buf[{r_cnt, 3'b000} +: 8] <= ram_rdata;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == w_last) r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= 2'd0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  // Memory port, stall request and writeback; all forced low during reset.
  always_comb begin
    ram_req      = 1'b0;
    ram_rw       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = 8'h00;
    stallreq_mem = NoStop;
    wb_we        = Disable;
    wb_waddr     = 5'd0;
    wb_wdata     = '0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_err = 1'b0;
`endif
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            stallreq_mem = Stop;
          end else if (w_misalign) begin
`ifdef MEM_ALIGN_CHECK_EN
            misalign_err = 1'b1;
`endif
            wb_waddr = mem_waddr;
          end else begin
            wb_we    = mem_we & mem_flag;
            wb_waddr = mem_waddr;
            wb_wdata = mem_alu;
          end
        end
        BUSY: begin
          ram_req      = 1'b1;
          ram_rw       = w_is_store;
          ram_addr     = mem_alu[ADDR_W-1:0] + ADDR_W'(r_cnt);
          ram_wdata    = mem_rdata2[{r_cnt, 3'b000} +: 8];
          stallreq_mem = Stop;
          wb_waddr     = mem_waddr;
        end
        DONE: begin
          wb_waddr = mem_waddr;
          if (w_is_load) begin
            wb_we    = mem_we;
            wb_wdata = w_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  mem_opcode;
  logic [5:0]  mem_opt;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_alu;
  logic        mem_cond;
  logic [31:0] mem_rdata2;
  logic        mem_flag;
  logic        ram_req;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_ready;
  logic        stallreq_mem;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .mem_opcode   (mem_opcode),
    .mem_opt      (mem_opt),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_alu      (mem_alu),
    .mem_cond     (mem_cond),
    .mem_rdata2   (mem_rdata2),
    .mem_flag     (mem_flag),
    .ram_req      (ram_req),
    .ram_rw       (ram_rw),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_ready    (ram_ready),
    .stallreq_mem (stallreq_mem),
    .wb_we        (wb_we),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata)
`ifdef MEM_ALIGN_CHECK_EN
    ,.misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one load/store, serve each byte after a one-cycle wait, check DONE.
  task automatic run_mem(input string tag, input logic [6:0] opc, input logic [5:0] opt,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] rbytes, input int n, input logic exp_we,
                         input logic [31:0] exp_wb);
    logic is_st;
    is_st = (opc == STORE);
    @(negedge clk);
    mem_flag = 1'b1; mem_opcode = opc; mem_opt = opt; mem_we = 1'b1;
    mem_waddr = 5'd7; mem_alu = alu; mem_rdata2 = wd; ram_ready = 1'b0;
    #1;
    chk({tag, "_start_stall"}, stallreq_mem, 1);
    chk({tag, "_start_req"}, ram_req, 0);
    chk({tag, "_start_we"}, wb_we, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ram_ready = 1'b0;
      #1;
      chk({tag, "_req"}, ram_req, 1);
      chk({tag, "_addr"}, ram_addr, alu + i);
      chk({tag, "_rw"}, ram_rw, is_st);
      chk({tag, "_stall"}, stallreq_mem, 1);
      chk({tag, "_busy_we"}, wb_we, 0);
      if (is_st) chk({tag, "_wdata"}, ram_wdata, wd[8*i +: 8]);
      @(negedge clk);
      ram_ready = 1'b1; ram_rdata = rbytes[8*i +: 8];
      #1;
      chk({tag, "_addr_rdy"}, ram_addr, alu + i);
    end
    @(negedge clk);
    ram_ready = 1'b0;
    #1;
    chk({tag, "_done_stall"}, stallreq_mem, 0);
    chk({tag, "_done_req"}, ram_req, 0);
    chk({tag, "_done_we"}, wb_we, exp_we);
    if (exp_we) begin
      chk({tag, "_done_waddr"}, wb_waddr, 7);
      chk({tag, "_done_data"}, wb_wdata, exp_wb);
    end
    @(negedge clk);
    mem_flag = 1'b0;
    #1;
    chk({tag, "_after_stall"}, stallreq_mem, 0);
    chk({tag, "_after_req"}, ram_req, 0);
  endtask

  initial begin
    rst = 1'b1; mem_opcode = 7'b0110011; mem_opt = OptNOP; mem_we = 1'b1;
    mem_waddr = 5'd5; mem_alu = 32'h1234; mem_cond = 1'b0; mem_rdata2 = 32'h0;
    mem_flag = 1'b1; ram_rdata = 8'h00; ram_ready = 1'b0;

    // Reset: every output low even with a valid instruction present.
    @(negedge clk); #1;
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_stall", stallreq_mem, 0);
    chk("rst_req", ram_req, 0);

    // ADD passthrough with a stray ram_ready in IDLE.
    @(negedge clk);
    rst = 1'b0; ram_ready = 1'b1;
    #1;
    chk("add_we", wb_we, 1);
    chk("add_waddr", wb_waddr, 5);
    chk("add_wdata", wb_wdata, 32'h1234);
    chk("add_stall", stallreq_mem, 0);
    chk("add_req", ram_req, 0);

    // Bubble.
    @(negedge clk);
    mem_flag = 1'b0; ram_ready = 1'b0;
    #1;
    chk("bub_we", wb_we, 0);
    chk("bub_req", ram_req, 0);

    run_mem("lw",  LOAD,  OptLW,  32'h100, 32'h0, 32'h12345678, 4, 1'b1, 32'h12345678);
    run_mem("lb",  LOAD,  OptLB,  32'h200, 32'h0, 32'h00000080, 1, 1'b1, 32'hFFFFFF80);
    run_mem("lbu", LOAD,  OptLBU, 32'h201, 32'h0, 32'h00000080, 1, 1'b1, 32'h00000080);
    run_mem("lhu", LOAD,  OptLHU, 32'h300, 32'h0, 32'h00008001, 2, 1'b1, 32'h00008001);
    run_mem("lh",  LOAD,  OptLH,  32'h302, 32'h0, 32'h00008001, 2, 1'b1, 32'hFFFF8001);
    run_mem("sh",  STORE, OptSH,  32'h20, 32'hAABBCCDD, 32'h0, 2, 1'b0, 32'h0);
    run_mem("sw",  STORE, OptSW,  32'h40, 32'h11223344, 32'h0, 4, 1'b0, 32'h0);
`ifndef MEM_ALIGN_CHECK_EN
    // Misaligned word crossing the top of the address space wraps to 0.
    run_mem("lw_wrap", LOAD, OptLW, 32'hFFFFFFFE, 32'h0, 32'hA1B2C3D4, 4, 1'b1, 32'hA1B2C3D4);
`endif

    // Reset in the middle of an LW after two bytes.
    @(negedge clk);
    mem_flag = 1'b1; mem_opcode = LOAD; mem_opt = OptLW; mem_we = 1'b1;
    mem_waddr = 5'd9; mem_alu = 32'h500;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); ram_ready = 1'b0;
      @(negedge clk); ram_ready = 1'b1; ram_rdata = 8'h5A;
    end
    @(negedge clk);
    ram_ready = 1'b0;
    #1;
    chk("mid_addr", ram_addr, 32'h502);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", ram_req, 0);
    chk("mid_rst_stall", stallreq_mem, 0);
    @(negedge clk);
    rst = 1'b0; mem_flag = 1'b0;
    #1;
    chk("post_rst_req", ram_req, 0);
    chk("post_rst_stall", stallreq_mem, 0);
    chk("post_rst_we", wb_we, 0);
    @(negedge clk);
    mem_flag = 1'b1; mem_opcode = 7'b0010011; mem_alu = 32'hCAFE;
    #1;
    chk("post_rst_pass_we", wb_we, 1);
    chk("post_rst_pass_data", wb_wdata, 32'hCAFE);
    chk("post_rst_pass_req", ram_req, 0);
    run_mem("lb_after_rst", LOAD, OptLB, 32'h600, 32'h0, 32'h0000007F, 1, 1'b1, 32'h0000007F);

`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    mem_flag = 1'b1; mem_opcode = LOAD; mem_opt = OptLW; mem_alu = 32'h102;
    #1;
    chk("mis_err", misalign_err, 1);
    chk("mis_req", ram_req, 0);
    chk("mis_stall", stallreq_mem, 0);
    chk("mis_we", wb_we, 0);
    @(negedge clk);
    mem_flag = 1'b0;
    #1;
    chk("mis_err_clear", misalign_err, 0);
    chk("mis_req_after", ram_req, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
